// File: rtl/cache_mem_interconnect.sv
// Round-robin read-burst interconnect: N cache refill masters share one narrow memory port.
// Each wide beat is fetched as RATIO sequential narrow reads and reassembled little-endian.
module cache_mem_interconnect #(
    parameter int N_MASTERS   = 2,
    parameter int MEM_WIDTH   = 32,
    parameter int RATIO       = 2,
    parameter int BURST_WIDTH = 4,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic [N_MASTERS*ADDR_WIDTH-1:0]  m_address,
    input  logic [N_MASTERS-1:0]             m_read,
    input  logic [N_MASTERS*BURST_WIDTH-1:0] m_burstcount,
    output logic [N_MASTERS-1:0]             m_waitrequest,
    output logic [MEM_WIDTH*RATIO-1:0]       m_readdata,
    output logic [N_MASTERS-1:0]             m_readdatavalid,
    output logic [ADDR_WIDTH-1:0]            mem_address,
    output logic                             mem_read,
    input  logic                             mem_waitrequest,
    input  logic                             mem_readdatavalid,
    input  logic [MEM_WIDTH-1:0]             mem_readdata,
    output logic [1:0]                       dbg_state
);

    localparam int WIDE_W = MEM_WIDTH * RATIO;
    localparam int LG     = $clog2(WIDE_W / 8);
    localparam int SUB_W  = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;

    localparam logic [ADDR_WIDTH-1:0] STEP       = ADDR_WIDTH'(MEM_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~((ADDR_WIDTH'(1) << LG) - ADDR_WIDTH'(1));
    localparam logic [SUB_W-1:0]      SUB_LAST   = SUB_W'(RATIO - 1);
    localparam logic [GW-1:0]         GRANT_RST  = GW'(N_MASTERS - 1);
    localparam logic [BURST_WIDTH-1:0] ONE_BEAT  = BURST_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_DATA = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [GW-1:0]          last_grant_q, last_grant_d;
    logic [ADDR_WIDTH-1:0]  addr_q, addr_d;
    logic [BURST_WIDTH-1:0] beats_q, beats_d;
    logic [SUB_W-1:0]       sub_q, sub_d;
    logic [WIDE_W-1:0]      asm_q, asm_d;
    logic [WIDE_W-1:0]      rdata_q, rdata_d;
    logic [N_MASTERS-1:0]   rvalid_q, rvalid_d;
    logic                   mem_read_q, mem_read_d;

    logic                   any_req;
    logic [GW-1:0]          win_idx;
    logic [ADDR_WIDTH-1:0]  sel_addr;
    logic [BURST_WIDTH-1:0] sel_burst;

    // Round-robin search starts one past the last granted master and wraps.
    always_comb begin
        any_req   = 1'b0;
        win_idx   = '0;
        sel_addr  = '0;
        sel_burst = '0;
        for (int k = 1; k <= N_MASTERS; k++) begin
            for (int i = 0; i < N_MASTERS; i++) begin
                if (!any_req && m_read[i] &&
                    ((int'(last_grant_q) + k) % N_MASTERS == i)) begin
                    any_req   = 1'b1;
                    win_idx   = GW'(i);
                    sel_addr  = m_address[i*ADDR_WIDTH +: ADDR_WIDTH];
                    sel_burst = m_burstcount[i*BURST_WIDTH +: BURST_WIDTH];
                end
            end
        end
    end

    // Master handshake: a request is taken in the cycle its m_waitrequest is low,
    // which only happens in IDLE for the arbitration winner; burst data then
    // returns as one m_readdatavalid pulse per wide beat.
    always_comb begin
        m_waitrequest = '1;
        if (!reset && state_q == IDLE && any_req) begin
            m_waitrequest[win_idx] = 1'b0;
        end
    end

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        beats_d      = beats_q;
        sub_d        = sub_q;
        asm_d        = asm_q;
        rdata_d      = rdata_q;
        rvalid_d     = '0;
        mem_read_d   = mem_read_q;

        case (state_q)
            IDLE: begin
                if (any_req) begin
                    last_grant_d = win_idx;
                    addr_d       = sel_addr & ALIGN_MASK;
                    beats_d      = sel_burst;
                    sub_d        = '0;
                    if (sel_burst != '0) begin
                        state_d    = ISSUE;
                        mem_read_d = 1'b1;
                    end
                end
            end

            ISSUE: begin
                if (!mem_waitrequest) begin
                    state_d    = WAIT_DATA;
                    mem_read_d = 1'b0;
                    addr_d     = addr_q + STEP;
                end
            end

            WAIT_DATA: begin
                if (mem_readdatavalid) begin
                    for (int j = 0; j < RATIO; j++) begin
                        if (sub_q == SUB_W'(j)) begin
                            asm_d[j*MEM_WIDTH +: MEM_WIDTH] = mem_readdata;
                        end
                    end
                    if (sub_q == SUB_LAST) begin
                        sub_d                  = '0;
                        rdata_d                = asm_d;
                        rvalid_d[last_grant_q] = 1'b1;
                        beats_d                = beats_q - ONE_BEAT;
                        if (beats_q == ONE_BEAT) begin
                            state_d = IDLE;
                        end else begin
                            state_d    = ISSUE;
                            mem_read_d = 1'b1;
                        end
                    end else begin
                        sub_d      = sub_q + 1'b1;
                        state_d    = ISSUE;
                        mem_read_d = 1'b1;
                    end
                end
            end

            default: begin
                state_d    = IDLE;
                mem_read_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= GRANT_RST;
            addr_q       <= '0;
            beats_q      <= '0;
            sub_q        <= '0;
            asm_q        <= '0;
            rdata_q      <= '0;
            rvalid_q     <= '0;
            mem_read_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            beats_q      <= beats_d;
            sub_q        <= sub_d;
            asm_q        <= asm_d;
            rdata_q      <= rdata_d;
            rvalid_q     <= rvalid_d;
            mem_read_q   <= mem_read_d;
        end
    end

    assign m_readdata      = rdata_q;
    assign m_readdatavalid = rvalid_q;
    assign mem_address     = addr_q;
    assign mem_read        = mem_read_q;
    assign dbg_state       = state_q;

endmodule

// File: tb/tb_cache_mem_interconnect.sv
// Bench for cache_mem_interconnect: default 2-master 64/32 build plus a 1-master RATIO=4 16-bit build.
// A behavioural memory returns word = address; expected beats and addresses flow through queues.
module tb_cache_mem_interconnect;

    localparam int N  = 2;
    localparam int MW = 32;
    localparam int R  = 2;
    localparam int BW = 4;
    localparam int AW = 32;
    localparam int WW = MW * R;
    localparam int EW = N + WW;

    logic            clock = 1'b0;
    logic            reset;
    logic [N*AW-1:0] m_address;
    logic [N-1:0]    m_read;
    logic [N*BW-1:0] m_burstcount;
    logic [N-1:0]    m_waitrequest;
    logic [WW-1:0]   m_readdata;
    logic [N-1:0]    m_readdatavalid;
    logic [AW-1:0]   mem_address;
    logic            mem_read;
    logic            mem_waitrequest;
    logic            mem_readdatavalid;
    logic [MW-1:0]   mem_readdata;
    logic [1:0]      dbg_state;

    logic [31:0] a4_addr;
    logic [0:0]  a4_read;
    logic [3:0]  a4_burst;
    logic [0:0]  a4_wr;
    logic [63:0] a4_rdata;
    logic [0:0]  a4_rvalid;
    logic [31:0] a4_maddr;
    logic        a4_mread;
    logic        a4_mwr;
    logic        a4_mvalid;
    logic [15:0] a4_mdata;
    logic [1:0]  a4_state;

    cache_mem_interconnect #(
        .N_MASTERS(N), .MEM_WIDTH(MW), .RATIO(R), .BURST_WIDTH(BW), .ADDR_WIDTH(AW)
    ) dut (
        .clock(clock), .reset(reset),
        .m_address(m_address), .m_read(m_read), .m_burstcount(m_burstcount),
        .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
        .m_readdatavalid(m_readdatavalid), .mem_address(mem_address),
        .mem_read(mem_read), .mem_waitrequest(mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid), .mem_readdata(mem_readdata),
        .dbg_state(dbg_state)
    );

    cache_mem_interconnect #(
        .N_MASTERS(1), .MEM_WIDTH(16), .RATIO(4), .BURST_WIDTH(4), .ADDR_WIDTH(32)
    ) dut4 (
        .clock(clock), .reset(reset),
        .m_address(a4_addr), .m_read(a4_read), .m_burstcount(a4_burst),
        .m_waitrequest(a4_wr), .m_readdata(a4_rdata),
        .m_readdatavalid(a4_rvalid), .mem_address(a4_maddr),
        .mem_read(a4_mread), .mem_waitrequest(a4_mwr),
        .mem_readdatavalid(a4_mvalid), .mem_readdata(a4_mdata),
        .dbg_state(a4_state)
    );

    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;

    logic [EW-1:0] exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [WW-1:0] last_beat = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [N-1:0] oh(input int i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    task automatic push_burst(input int mst, input logic [AW-1:0] addr, input int burst);
        logic [AW-1:0] a;
        logic [WW-1:0] beat;
        a = addr & ~(AW'(WW / 8) - AW'(1));
        for (int b = 0; b < burst; b++) begin
            beat = '0;
            for (int j = 0; j < R; j++) begin
                beat[j*MW +: MW] = a[MW-1:0];
                exp_addr_q.push_back(a);
                a = a + AW'(MW / 8);
            end
            exp_q.push_back({oh(mst), beat});
        end
    endtask

    // Memory model and output monitor for the default build
    int            stall_cfg  = 0;
    int            stall_done = 0;
    int            acc_cnt    = 0;
    logic          pend       = 1'b0;
    logic [AW-1:0] pend_addr  = '0;
    logic          stray      = 1'b0;
    logic          prev_rd    = 1'b0;
    logic          prev_wr    = 1'b0;
    logic [AW-1:0] prev_addr  = '0;

    always @(negedge clock) begin
        logic [EW-1:0] e;
        if (reset) begin
            mem_readdatavalid = 1'b0;
            mem_waitrequest   = 1'b1;
            pend              = 1'b0;
            prev_rd           = 1'b0;
            stall_done        = 0;
        end else begin
            if (m_readdatavalid != '0) begin
                check("valid_onehot", 128'($onehot(m_readdatavalid)), 128'd1);
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_beat: got valid %0b data %0h, expected no beat",
                             m_readdatavalid, m_readdata);
                end else begin
                    e = exp_q.pop_front();
                    check("beat", {m_readdatavalid, m_readdata}, e);
                    last_beat = e[WW-1:0];
                end
            end
            if (prev_rd && prev_wr) begin
                check("stall_read_held", mem_read, 1'b1);
                check("stall_addr_held", mem_address, prev_addr);
            end
            mem_readdatavalid = pend || stray;
            mem_readdata      = stray ? 32'hDEAD_BEEF : pend_addr[MW-1:0];
            pend              = 1'b0;
            if (!mem_read) begin
                stall_done      = 0;
                mem_waitrequest = 1'b1;
            end else if (stall_done < stall_cfg) begin
                stall_done++;
                mem_waitrequest = 1'b1;
            end else begin
                mem_waitrequest = 1'b0;
                pend            = 1'b1;
                pend_addr       = mem_address;
                acc_cnt++;
                if (exp_addr_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_read: got address %0h, expected no read", mem_address);
                end else begin
                    check("mem_address", mem_address, exp_addr_q.pop_front());
                end
            end
            prev_rd   = mem_read;
            prev_wr   = mem_waitrequest;
            prev_addr = mem_address;
        end
    end

    // Zero-wait memory for the RATIO=4 build
    logic        a4_pend  = 1'b0;
    logic [31:0] a4_paddr = '0;
    logic [31:0] a4_seen[$];

    always @(negedge clock) begin
        a4_mvalid = a4_pend;
        a4_mdata  = a4_paddr[15:0];
        a4_pend   = a4_mread && !reset;
        a4_paddr  = a4_maddr;
        if (a4_mread && !reset) a4_seen.push_back(a4_maddr);
    end

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        do begin
            @(posedge clock);
            #1;
            n++;
        end while (dbg_state != 2'd0 && n < 500);
        check({tag, "_idle"}, dbg_state, 2'd0);
    endtask

    task automatic run_req(input int mst, input logic [AW-1:0] addr, input int burst,
                           input int stall, input int exp_cyc, input string tag);
        int n;
        logic [N-1:0] exp_wr;
        @(negedge clock);
        stall_cfg                  = stall;
        m_address[mst*AW +: AW]    = addr;
        m_burstcount[mst*BW +: BW] = BW'(burst);
        m_read                     = oh(mst);
        #1;
        exp_wr = ~oh(mst);
        check({tag, "_grant"}, m_waitrequest, exp_wr);
        push_burst(mst, addr, burst);
        @(posedge clock);
        #1;
        m_read = '0;
        n = 1;
        while (dbg_state != 2'd0 && n < 500) begin
            @(posedge clock);
            #1;
            n++;
        end
        check({tag, "_cycles"}, n, exp_cyc);
        if (burst > 0) check({tag, "_last_valid"}, m_readdatavalid, oh(mst));
        else           check({tag, "_no_read"}, mem_read, 1'b0);
    endtask

    typedef struct {
        int          mst;
        logic [31:0] addr;
        int          burst;
        int          stall;
        int          cycles;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base;
        int n;

        vecs[0] = '{0, 32'h0000_1004, 4,  0, 17};
        vecs[1] = '{1, 32'h0000_2000, 1,  0, 5};
        vecs[2] = '{0, 32'h0000_300F, 2,  3, 21};
        vecs[3] = '{1, 32'h0000_7FF0, 3,  1, 19};
        vecs[4] = '{0, 32'hFFFF_FFF8, 1,  0, 5};
        vecs[5] = '{1, 32'h0000_0040, 0,  0, 1};
        vecs[6] = '{1, 32'h0000_0A0C, 8,  0, 33};
        vecs[7] = '{0, 32'h0000_0100, 15, 0, 61};

        reset        = 1'b1;
        m_address    = '0;
        m_read       = '0;
        m_burstcount = '0;
        a4_addr      = '0;
        a4_read      = 1'b0;
        a4_burst     = '0;
        a4_mwr       = 1'b0;
        a4_mvalid    = 1'b0;
        a4_mdata     = '0;
        mem_waitrequest   = 1'b1;
        mem_readdatavalid = 1'b0;
        mem_readdata      = '0;

        repeat (3) @(negedge clock);
        check("rst_mem_read", mem_read, 1'b0);
        check("rst_mem_address", mem_address, '0);
        check("rst_rdata", m_readdata, '0);
        check("rst_rvalid", m_readdatavalid, '0);
        check("rst_waitreq", m_waitrequest, 2'b11);
        check("rst_state", dbg_state, 2'd0);
        reset = 1'b0;

        // Simultaneous requests rotate m0 -> m1 -> m0
        @(negedge clock);
        m_address    = {32'h0000_6000, 32'h0000_5000};
        m_burstcount = {4'd1, 4'd2};
        m_read       = 2'b11;
        #1;
        check("rr_first", m_waitrequest, 2'b10);
        push_burst(0, 32'h0000_5000, 2);
        @(posedge clock);
        #1;
        m_address[31:0]   = 32'h0000_5100;
        m_burstcount[3:0] = 4'd1;
        wait_idle("rr_m0");
        check("rr_second", m_waitrequest, 2'b01);
        check("rr_beat_at_idle", m_readdatavalid, 2'b01);
        push_burst(1, 32'h0000_6000, 1);
        @(posedge clock);
        #1;
        wait_idle("rr_m1");
        check("rr_third", m_waitrequest, 2'b10);
        push_burst(0, 32'h0000_5100, 1);
        @(posedge clock);
        #1;
        m_read = '0;
        wait_idle("rr_m0b");

        for (int i = 0; i < 8; i++) begin
            run_req(vecs[i].mst, vecs[i].addr, vecs[i].burst, vecs[i].stall,
                    vecs[i].cycles, $sformatf("vec%0d", i));
        end
        stall_cfg = 0;
        repeat (3) @(posedge clock);
        #1;
        check("rdata_hold", m_readdata, last_beat);

        // Asynchronous reset after three of eight narrow reads
        @(negedge clock);
        base              = acc_cnt;
        m_address[31:0]   = 32'h0000_8000;
        m_burstcount[3:0] = 4'd4;
        m_read            = 2'b01;
        push_burst(0, 32'h0000_8000, 4);
        @(posedge clock);
        #1;
        m_read = '0;
        n = 0;
        while (acc_cnt < base + 3 && n < 100) begin
            @(negedge clock);
            n++;
        end
        check("rst_three_reads", acc_cnt - base, 3);
        @(posedge clock);
        #2;
        reset  = 1'b1;
        m_read = 2'b11;
        #1;
        check("arst_mem_read", mem_read, 1'b0);
        check("arst_mem_address", mem_address, '0);
        check("arst_rdata", m_readdata, '0);
        check("arst_rvalid", m_readdatavalid, '0);
        check("arst_waitreq", m_waitrequest, 2'b11);
        check("arst_state", dbg_state, 2'd0);
        exp_q.delete();
        exp_addr_q.delete();
        repeat (2) @(negedge clock);
        m_read = '0;
        reset  = 1'b0;
        @(posedge clock);
        #1;
        stray = 1'b1;
        @(posedge clock);
        #1;
        stray = 1'b0;
        @(posedge clock);
        #1;
        check("stray_state", dbg_state, 2'd0);
        check("stray_rdata", m_readdata, '0);
        check("stray_rvalid", m_readdatavalid, '0);

        @(negedge clock);
        m_address    = {32'h0000_A000, 32'h0000_9000};
        m_burstcount = {4'd2, 4'd1};
        m_read       = 2'b11;
        #1;
        check("fresh_first", m_waitrequest, 2'b10);
        push_burst(0, 32'h0000_9000, 1);
        @(posedge clock);
        #1;
        wait_idle("fresh_m0");
        check("fresh_second", m_waitrequest, 2'b01);
        push_burst(1, 32'h0000_A000, 2);
        @(posedge clock);
        #1;
        m_read = '0;
        wait_idle("fresh_m1");

        // RATIO=4, 16-bit memory, address counter wraps past 0xFFFFFFFE
        @(negedge clock);
        a4_addr  = 32'hFFFF_FFF8;
        a4_burst = 4'd1;
        a4_read  = 1'b1;
        #1;
        check("r4_grant", a4_wr, 1'b0);
        @(posedge clock);
        #1;
        a4_read = 1'b0;
        n = 1;
        while (a4_state != 2'd0 && n < 100) begin
            @(posedge clock);
            #1;
            n++;
        end
        check("r4_cycles", n, 9);
        check("r4_rvalid", a4_rvalid, 1'b1);
        check("r4_rdata", a4_rdata, 64'hFFFE_FFFC_FFFA_FFF8);
        check("r4_reads", a4_seen.size(), 4);
        for (int i = 0; i < 4 && i < a4_seen.size(); i++) begin
            check($sformatf("r4_addr%0d", i), a4_seen[i], 32'hFFFF_FFF8 + 32'(2 * i));
        end
        check("r4_wrap", a4_maddr, 32'h0);

        repeat (2) @(negedge clock);
        check("exp_q_empty", exp_q.size(), 0);
        check("exp_addr_q_empty", exp_addr_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2_000_000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation still running, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cache_mem_interconnect.md
# cache_mem_interconnect

Parametrised read-burst interconnect between N cache refill masters and one narrow single-word memory port. Arbitrates round-robin between masters, accepts one burst at a time, splits each wide cache beat into RATIO sequential narrow memory reads, reassembles the narrow words and returns wide beats to the granted master. It replaces the fixed single-master 64-to-32 converter: instruction and data caches now share one memory port.

## Interface
- N_MASTERS, 2: number of cache masters (1..8).
- MEM_WIDTH, 32: memory data width in bits.
- RATIO, 2: cache beat width / MEM_WIDTH (power of two, 1..8).
- BURST_WIDTH, 4: burstcount width.
- ADDR_WIDTH, 32: byte address width.

- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- m_address  in  N_MASTERS*ADDR_WIDTH  per-master byte address, master i in bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- m_read  in  N_MASTERS  per-master burst request.
- m_burstcount  in  N_MASTERS*BURST_WIDTH  per-master beat count.
- m_waitrequest  out  N_MASTERS  per-master stall; low = request accepted this cycle.
- m_readdata  out  MEM_WIDTH*RATIO  wide beat, shared by all masters.
- m_readdatavalid  out  N_MASTERS  per-master beat valid (one-hot or zero).
- mem_address  out  ADDR_WIDTH  narrow read address.
- mem_read  out  1  narrow read request.
- mem_waitrequest  in  1  memory stall.
- mem_readdatavalid  in  1  narrow read data valid.
- mem_readdata  in  MEM_WIDTH  narrow read data.

## Operation
- States: IDLE, ISSUE, WAIT_DATA.
- IDLE: if any m_read high, round-robin winner chosen combinationally, starting search at (last_grant+1) mod N_MASTERS; winner's m_waitrequest driven low this cycle; address, burstcount, grant index latched at edge. Non-winners keep waitrequest high.
- Latched address: low log2(MEM_WIDTH*RATIO/8) bits forced to zero.
- Burstcount 0: accepted, no memory traffic, stays IDLE, last_grant updated.
- Burstcount B>0: total narrow reads = B*RATIO; go to ISSUE.
- ISSUE: mem_read=1, mem_address=current address. Held stable while mem_waitrequest=1. On mem_waitrequest=0: go WAIT_DATA, address += MEM_WIDTH/8.
- WAIT_DATA: on mem_readdatavalid, write mem_readdata into slot sub_idx of assembly register (slot 0 = bits [MEM_WIDTH-1:0], little-endian), sub_idx++. When sub_idx wraps from RATIO-1: register full beat to m_readdata, pulse m_readdatavalid[grant], beat counter--. Then: reads remaining -> ISSUE; none -> IDLE.
- One narrow read outstanding at a time. mem_readdatavalid outside WAIT_DATA ignored.
- m_readdata holds last beat when no valid asserted.
- Address counter wraps modulo 2^ADDR_WIDTH.
- Master deasserting m_read mid-burst has no effect; burst completes.
- Reset (any time, incl. mid-burst): state IDLE, last_grant = N_MASTERS-1 (master 0 first priority), counters 0, mem_read 0, mem_address 0, m_readdata 0, m_readdatavalid 0, m_waitrequest all 1.

## Timing
- m_waitrequest low is combinational in IDLE only; never low in ISSUE/WAIT_DATA.
- Acceptance edge -> mem_read high next cycle (1-cycle latency).
- mem_read deasserted the cycle after memory accept; next mem_read earliest the cycle after the mem_readdatavalid that completed the previous read.
- m_readdatavalid registered: high the cycle after the mem_readdatavalid that fills slot RATIO-1; exactly one cycle per beat.
- Last beat's m_readdatavalid coincides with return to IDLE; a new grant may occur in that same cycle.
- Zero-wait memory with 1-cycle data latency: burst of B beats takes 1 + 2*B*RATIO cycles from accept to IDLE.

## Test plan
- Single master, N=2, RATIO=2, m0 reads 0x1004 burst 4, memory returns word=address -> mem_address 0x1000,0x1004..0x101C; m_readdata beats 0x0000100400001000, 0x0000100C00001008, ..., 4 pulses on m_readdatavalid[0] only.
- Both masters request in same cycle after reset -> m0 granted first, m1 granted immediately after m0's last beat; third simultaneous request grants m0 again (round-robin).
- mem_waitrequest high 3 cycles on every read -> mem_read/mem_address stable through stall, data order unchanged, no lost or duplicated beat.
- Burstcount 0 from m1 -> m_waitrequest[1] low one cycle, no mem_read, state IDLE next cycle.
- Reset asserted after 3 of 8 narrow reads -> all outputs at reset values immediately (asynchronous), stray mem_readdatavalid after reset ignored, next request starts fresh.
- RATIO=4, MEM_WIDTH=16 build, address 0xFFFFFFF8 burst 1 -> mem_address 0xFFFFFFF8,0xFFFFFFFA,0xFFFFFFFC,0xFFFFFFFE, one 64-bit beat, counter wraps to 0x00000000 without fault.
